// File: rtl/cdc_handshake_arbiter.sv
// Round-robin arbiter feeding one toggle-handshake CDC channel.
// A single transfer is outstanding at a time; a missing ack raises err_timeout and parks in StStall.
module cdc_handshake_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic [DATA_BITS-1:0]           tx_data,
  output logic                           tx_req_tgl,
  input  logic                           rx_ack_tgl,
  output logic                           busy,
  output logic                           err_timeout
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMR_W-1:0] TMO_VAL = TMR_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWaitAck, StStall} state_e;

  state_e                 r_state, w_state_nxt;
  logic [NUM_REQ-1:0]     r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0]     r_done, w_done_nxt;
  logic                   r_err, w_err_nxt;
  logic [DATA_BITS-1:0]   r_tx_data, w_tx_data_nxt;
  logic                   r_tgl, w_tgl_nxt;
  logic [IDX_W-1:0]       r_last, w_last_nxt;
  logic [TMR_W-1:0]       r_timer, w_timer_nxt;

  logic                   w_found;
  logic [IDX_W-1:0]       w_sel;
  int unsigned            w_idx;
  logic [DATA_BITS-1:0]   w_sel_data;
  logic                   w_ack_match;
  logic [TMR_W-1:0]       w_timer_inc;
  logic                   w_tmo;

  // Search starts one past the last grant so every requester is eventually served.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_last;
    w_idx   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(r_last) + k) % NUM_REQ;
      if (!w_found && req[w_idx[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_sel == IDX_W'(i)) w_sel_data = req_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  assign w_ack_match = (rx_ack_tgl == r_tgl);
  assign w_timer_inc = (r_timer == '1) ? r_timer : r_timer + 1'b1;
  // Fires in the TIMEOUT_CYCLES-th WAIT_ACK cycle; an ack in that same cycle takes priority.
  assign w_tmo       = (TIMEOUT_CYCLES != 0) && (w_timer_inc >= TMO_VAL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_grant   <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_tx_data <= '0;
      r_tgl     <= 1'b0;
      r_last    <= IDX_W'(NUM_REQ - 1);
      r_timer   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_tgl     <= w_tgl_nxt;
      r_last    <= w_last_nxt;
      r_timer   <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:    if (w_found) w_state_nxt = StWaitAck;
      StWaitAck: begin
        if (w_ack_match)  w_state_nxt = StIdle;
        else if (w_tmo)   w_state_nxt = StStall;
      end
      StStall:   if (w_ack_match) w_state_nxt = StIdle;
      default:   w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_grant_nxt   = '0;
    w_done_nxt    = '0;
    w_err_nxt     = 1'b0;
    w_tx_data_nxt = r_tx_data;
    w_tgl_nxt     = r_tgl;
    w_last_nxt    = r_last;
    w_timer_nxt   = r_timer;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_grant_nxt   = NUM_REQ'(1) << w_sel;
          w_tx_data_nxt = w_sel_data;
          w_tgl_nxt     = ~r_tgl;
          w_last_nxt    = w_sel;
          w_timer_nxt   = '0;
        end
      end
      StWaitAck: begin
        w_timer_nxt = w_timer_inc;
        if (w_ack_match) w_done_nxt = NUM_REQ'(1) << r_last;
        else if (w_tmo)  w_err_nxt  = 1'b1;
      end
      StStall: begin
        if (w_ack_match) w_done_nxt = NUM_REQ'(1) << r_last;
      end
      default: ;
    endcase
  end

  assign grant       = r_grant;
  assign done        = r_done;
  assign err_timeout = r_err;
  assign tx_data     = r_tx_data;
  assign tx_req_tgl  = r_tgl;
  assign busy        = (r_state != StIdle);

endmodule

// File: tb/tb_cdc_handshake_arbiter.sv
// Directed bench: table of arbitration transactions plus hand sequences for
// timeout, ack/timeout collision, reset mid-transfer, withdrawn request and stray ack.
module tb_cdc_handshake_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [7:0]  tx_data;
  logic        tx_req_tgl;
  logic        rx_ack_tgl;
  logic        busy;
  logic        err_timeout;

  int n_cmp  = 0;
  int n_fail = 0;
  logic exp_tgl;

  cdc_handshake_arbiter #(
    .NUM_REQ       (4),
    .DATA_BITS     (8),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .done       (done),
    .tx_data    (tx_data),
    .tx_req_tgl (tx_req_tgl),
    .rx_ack_tgl (rx_ack_tgl),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          ack_dly;
    logic [3:0]  exp_grant;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic run_txn(input vec_t v);
    req      = v.req;
    req_data = v.data;
    @(negedge clk);
    exp_tgl = ~exp_tgl;
    chk("grant", {28'd0, grant}, {28'd0, v.exp_grant});
    chk("tx_data", {24'd0, tx_data}, {24'd0, v.exp_data});
    chk("tx_req_tgl", {31'd0, tx_req_tgl}, {31'd0, exp_tgl});
    chk("busy_wait", {31'd0, busy}, 32'd1);
    req = 4'b0000;
    if (v.ack_dly > 1) begin
      @(negedge clk);
      chk("grant_pulse", {28'd0, grant}, 32'd0);
      chk("done_early", {28'd0, done}, 32'd0);
      repeat (v.ack_dly - 2) @(negedge clk);
    end
    rx_ack_tgl = exp_tgl;
    @(negedge clk);
    chk("done", {28'd0, done}, {28'd0, v.exp_grant});
    chk("err_on_done", {31'd0, err_timeout}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{4'b1111, 32'h44332211, 2, 4'b0001, 8'h11};
    vecs[1] = '{4'b1111, 32'h44332211, 2, 4'b0010, 8'h22};
    vecs[2] = '{4'b1111, 32'h44332211, 2, 4'b0100, 8'h33};
    vecs[3] = '{4'b1111, 32'h44332211, 2, 4'b1000, 8'h44};
    vecs[4] = '{4'b1111, 32'h44332211, 2, 4'b0001, 8'h11};
    vecs[5] = '{4'b0001, 32'h000000A5, 3, 4'b0001, 8'hA5};
    vecs[6] = '{4'b1010, 32'hDEADBEEF, 1, 4'b0010, 8'hBE};
    vecs[7] = '{4'b1010, 32'hDEADBEEF, 2, 4'b1000, 8'hDE};
    vecs[8] = '{4'b0110, 32'h0F1E2D3C, 1, 4'b0010, 8'h2D};

    reset_n    = 1'b0;
    req        = 4'b0000;
    req_data   = 32'd0;
    rx_ack_tgl = 1'b0;
    exp_tgl    = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_tgl", {31'd0, tx_req_tgl}, 32'd0);
    chk("rst_grant", {28'd0, grant}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) run_txn(vecs[i]);
    @(negedge clk);
    chk("idle_after_table", {31'd0, busy}, 32'd0);

    // Timeout: ack withheld, err 8 cycles after grant, StStall until ack at cycle 20.
    req      = 4'b0001;
    req_data = 32'h000000C3;
    @(negedge clk);
    exp_tgl = ~exp_tgl;
    chk("tmo_grant", {28'd0, grant}, 32'h1);
    req = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("tmo_err", {31'd0, err_timeout}, (k == 8) ? 32'd1 : 32'd0);
      chk("tmo_done", {28'd0, done}, 32'd0);
    end
    @(negedge clk);
    chk("tmo_err_pulse", {31'd0, err_timeout}, 32'd0);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    repeat (10) @(negedge clk);
    chk("stall_no_done", {28'd0, done}, 32'd0);
    rx_ack_tgl = exp_tgl;
    @(negedge clk);
    chk("stall_done", {28'd0, done}, 32'h1);
    chk("stall_done_err", {31'd0, err_timeout}, 32'd0);
    @(negedge clk);
    chk("stall_idle", {31'd0, busy}, 32'd0);
    run_txn('{4'b0100, 32'h00770000, 1, 4'b0100, 8'h77});

    // Ack matches in the very cycle the timer would expire: ack wins.
    req      = 4'b1000;
    req_data = 32'h99000000;
    @(negedge clk);
    exp_tgl = ~exp_tgl;
    chk("sim_grant", {28'd0, grant}, 32'h8);
    req = 4'b0000;
    repeat (7) @(negedge clk);
    chk("sim_err_before", {31'd0, err_timeout}, 32'd0);
    rx_ack_tgl = exp_tgl;
    @(negedge clk);
    chk("sim_done", {28'd0, done}, 32'h8);
    chk("sim_err", {31'd0, err_timeout}, 32'd0);
    @(negedge clk);
    chk("sim_err_after", {31'd0, err_timeout}, 32'd0);
    chk("sim_idle", {31'd0, busy}, 32'd0);

    // Reset during WAIT_ACK abandons the transfer.
    req      = 4'b0001;
    req_data = 32'h000000AA;
    @(negedge clk);
    chk("mid_grant", {28'd0, grant}, 32'h1);
    req = 4'b0000;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_tx_data", {24'd0, tx_data}, 32'd0);
    chk("mid_tgl", {31'd0, tx_req_tgl}, 32'd0);
    chk("mid_done", {28'd0, done}, 32'd0);
    chk("mid_err", {31'd0, err_timeout}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n    = 1'b1;
    rx_ack_tgl = 1'b0;
    exp_tgl    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_done", {28'd0, done}, 32'd0);
    end
    req      = 4'b0100;
    req_data = 32'h00550000;
    @(negedge clk);
    exp_tgl = ~exp_tgl;
    chk("post_rst_grant", {28'd0, grant}, 32'h4);
    chk("post_rst_data", {24'd0, tx_data}, 32'h55);
    chk("post_rst_tgl", {31'd0, tx_req_tgl}, {31'd0, exp_tgl});
    req = 4'b0000;

    // Requester 1 pulses during WAIT_ACK then withdraws: never served.
    req = 4'b0010;
    @(negedge clk);
    req        = 4'b0000;
    rx_ack_tgl = exp_tgl;
    @(negedge clk);
    chk("wd_done", {28'd0, done}, 32'h4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wd_grant", {28'd0, grant}, 32'd0);
      chk("wd_no_done", {28'd0, done}, 32'd0);
    end

    // Stray ack toggle while idle.
    rx_ack_tgl = ~rx_ack_tgl;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stray_done", {28'd0, done}, 32'd0);
      chk("stray_busy", {31'd0, busy}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_arbiter.md
CDC_HANDSHAKE_ARBITER -- requirements
Module: cdc_handshake_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing one toggle-handshake CDC channel (2..8).
REQ-002 Parameter DATA_BITS, default 8, SHALL set the payload width per transfer.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, SHALL set the cycles allowed in WAIT_ACK before a timeout; 0 disables the timeout.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  NUM_REQ  per-requester transfer request, level, held until grant.
REQ-007 req_data  input  NUM_REQ*DATA_BITS  payloads; requester i occupies bits [i*DATA_BITS +: DATA_BITS].
REQ-008 grant  output  NUM_REQ  one-hot, one-cycle pulse when a request is accepted.
REQ-009 done  output  NUM_REQ  one-hot, one-cycle pulse when the granted transfer is acknowledged.
REQ-010 tx_data  output  DATA_BITS  registered payload driven into the CDC channel.
REQ-011 tx_req_tgl  output  1  request toggle into the CDC channel.
REQ-012 rx_ack_tgl  input  1  acknowledge toggle returned from the far domain, already synchronized to clk.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 err_timeout  output  1  one-cycle pulse on timeout.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT_ACK, STALL.
REQ-016 In IDLE with any req bit high, the next edge SHALL select one requester round-robin, starting the search at (last_grant+1) mod NUM_REQ.
REQ-017 On that edge: grant[sel]=1 for one cycle; tx_data=req_data slice sel; tx_req_tgl inverted; last_grant=sel; timer cleared; state=WAIT_ACK.
REQ-018 req_data SHALL be sampled only on the grant edge; tx_data SHALL hold until the next grant.
REQ-019 A req bit that drops before its grant SHALL be ignored, with no grant and no done.
REQ-020 req SHALL be ignored in WAIT_ACK and STALL; a req still high after done SHALL be re-arbitrated in IDLE.
REQ-021 In WAIT_ACK, when rx_ack_tgl==tx_req_tgl, the next edge SHALL pulse done[last_grant] and return to IDLE.
REQ-022 Minimum spacing SHALL be grant edge, >=1 WAIT_ACK cycle, done edge, then the next grant no earlier than the following edge.
REQ-023 The WAIT_ACK timer SHALL increment every WAIT_ACK cycle and saturate, never wrapping.
REQ-024 With TIMEOUT_CYCLES>0 and no acknowledge when the timer reaches TIMEOUT_CYCLES, the FSM SHALL pulse err_timeout and enter STALL.
REQ-025 If the ack match and the timeout occur in the same cycle, the ack SHALL win: done pulses, err_timeout does not, state=IDLE.
REQ-026 STALL SHALL wait, without a time limit, for rx_ack_tgl==tx_req_tgl, then pulse done[last_grant] and return to IDLE; no new toggle is issued while unmatched.
REQ-027 An rx_ack_tgl change while in IDLE SHALL be ignored and SHALL produce no done.
REQ-028 grant, done, and err_timeout SHALL never be high in the same cycle.

Reset
REQ-029 While reset_n=0, the block SHALL force: state=IDLE; grant=0, done=0, err_timeout=0, busy=0; tx_data=0; tx_req_tgl=0; timer=0; last_grant=NUM_REQ-1, so requester 0 is served first.
REQ-030 Reset in WAIT_ACK or STALL SHALL abandon the transfer with no done pulse.
REQ-031 After reset release, the far side must also be reset so that rx_ack_tgl=0.

Verification
REQ-032 Single request: req=0001, data0=0xA5; ack loops back after 3 cycles -> grant=0001, tx_data=0xA5, tx_req_tgl 0->1, busy high, done=0001 once, back to IDLE.
REQ-033 Contention: req=1111 held, each ack after 2 cycles -> grant order 0,1,2,3,0, exactly one done per grant.
REQ-034 Timeout: TIMEOUT_CYCLES=8, ack withheld -> err_timeout pulses 8 cycles after the grant, state STALL; ack at cycle 20 -> done pulses, back to IDLE, next request accepted.
REQ-035 Simultaneous ack and timeout: ack matches in the cycle the timer hits TIMEOUT_CYCLES -> done pulses, err_timeout stays 0.
REQ-036 Reset mid-transfer: reset_n low during WAIT_ACK -> all outputs 0 and no done; after release, req=0100 is granted.
REQ-037 Request withdrawn: req1 high 1 cycle during WAIT_ACK, then low -> no grant or done for requester 1; stray rx_ack_tgl toggle in IDLE -> no done.
